// File: rtl/reaction_pkg.sv
// reaction_pkg: state encoding and shared constants for the reaction-time round controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARM        = 3'd1,
        S_WAIT_DELAY = 3'd2,
        S_MEASURE    = 3'd3,
        S_RECORD     = 3'd4,
        S_FINISH     = 3'd5
    } state_t;

    localparam int MAX_MS_DEFAULT = 9999;

endpackage

// File: rtl/reaction_round_ctrl_rise_detect.sv
// rise_detect: registered rising-edge detector. History resets high so a level
// already asserted when reset releases never reports an edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_cur;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur  <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_cur  <= i_level;
            r_prev <= r_cur;
        end
    end

    assign o_rise = r_cur & ~r_prev;

endmodule

// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl: sequences reaction-game rounds and keeps last/best/average times.
// Build option FALSE_START_EN: a stop in WAIT_DELAY scores MAX_MS and flags false_start.
module reaction_round_ctrl
    import reaction_pkg::*;
#(
    parameter int NUM_ROUNDS = 4,
    parameter int CNT_W      = 16,
    parameter int MAX_MS     = MAX_MS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_ms,
    input  logic             start,
    input  logic             stop,
    output logic             delay_trigger,
    input  logic             delay_done,
    output logic             lfsr_en,
    output logic             count_clr,
    output logic             count_en,
    input  logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] round_time,
    output logic [CNT_W-1:0] best_time,
    output logic [CNT_W-1:0] avg_time,
    output logic             round_valid,
    output logic             false_start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       round_idx
);

    localparam int SUM_W  = CNT_W + 4;
    localparam int AVG_SH = $clog2(NUM_ROUNDS);

    state_t           r_state;
    state_t           w_next;
    logic             w_start_rise;
    logic             w_stop_rise;
    logic             w_timeout;
    logic             w_last_round;
    logic             w_session_start;
    logic             w_fs_evt;
    logic             w_unused_tick;
    logic [CNT_W-1:0] r_capture;
    logic [CNT_W-1:0] r_round_time;
    logic [CNT_W-1:0] r_best;
    logic [CNT_W-1:0] r_avg;
    logic [SUM_W-1:0] r_sum;
    logic [3:0]       r_idx;
    logic             r_round_valid;

    // The ms counter lives outside; the tick is only meaningful to it.
    assign w_unused_tick = tick_ms;

    rise_detect u_start_rise (
        .clk     (clk),
        .rst     (rst),
        .i_level (start),
        .o_rise  (w_start_rise)
    );

    rise_detect u_stop_rise (
        .clk     (clk),
        .rst     (rst),
        .i_level (stop),
        .o_rise  (w_stop_rise)
    );

    assign w_timeout       = (count >= CNT_W'(MAX_MS));
    assign w_last_round    = (r_idx == 4'(NUM_ROUNDS - 1));
    assign w_session_start = ((r_state == S_IDLE) || (r_state == S_FINISH)) && w_start_rise;

`ifdef FALSE_START_EN
    logic r_false_start;

    // delay_done in the same cycle takes priority and swallows the stop edge.
    assign w_fs_evt = (r_state == S_WAIT_DELAY) && !delay_done && w_stop_rise;

    always_ff @(posedge clk) begin
        if (rst)                  r_false_start <= 1'b0;
        else if (w_session_start) r_false_start <= 1'b0;
        else if (w_fs_evt)        r_false_start <= 1'b1;
    end

    assign false_start = r_false_start;
`else
    assign w_fs_evt    = 1'b0;
    assign false_start = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FINISH: if (w_start_rise) w_next = S_ARM;
            S_ARM:            w_next = S_WAIT_DELAY;
            S_WAIT_DELAY: begin
                if (delay_done)    w_next = S_MEASURE;
                else if (w_fs_evt) w_next = S_RECORD;
            end
            S_MEASURE:        if (w_stop_rise || w_timeout) w_next = S_RECORD;
            S_RECORD:         w_next = w_last_round ? S_FINISH : S_ARM;
            default:          w_next = S_IDLE;
        endcase
    end

    always_comb begin
        lfsr_en       = 1'b0;
        delay_trigger = 1'b0;
        count_clr     = 1'b0;
        count_en      = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                lfsr_en = ~rst;
                busy    = 1'b0;
            end
            S_ARM: begin
                delay_trigger = 1'b1;
                count_clr     = 1'b1;
            end
            S_MEASURE: count_en = 1'b1;
            S_FINISH: begin
                done = 1'b1;
                busy = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_capture     <= '0;
            r_round_time  <= '0;
            r_round_valid <= 1'b0;
            r_sum         <= '0;
            r_best        <= '1;
            r_avg         <= '0;
            r_idx         <= '0;
        end else begin
            r_round_valid <= 1'b0;
            if (w_session_start) begin
                r_sum  <= '0;
                r_best <= '1;
                r_idx  <= '0;
            end
            // A stop edge coinciding with the limit keeps the real count.
            if (w_fs_evt) begin
                r_capture <= CNT_W'(MAX_MS);
            end else if (r_state == S_MEASURE) begin
                if (w_stop_rise)    r_capture <= count;
                else if (w_timeout) r_capture <= CNT_W'(MAX_MS);
            end
            if (r_state == S_RECORD) begin
                r_round_time  <= r_capture;
                r_round_valid <= 1'b1;
                r_sum         <= r_sum + SUM_W'(r_capture);
                r_best        <= (r_capture < r_best) ? r_capture : r_best;
                r_idx         <= r_idx + 4'd1;
            end
            if (r_state == S_FINISH) r_avg <= CNT_W'(r_sum >> AVG_SH);
        end
    end

    assign round_time  = r_round_time;
    assign best_time   = r_best;
    assign avg_time    = r_avg;
    assign round_valid = r_round_valid;
    assign round_idx   = r_idx;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Self-checking bench for reaction_round_ctrl: models the external ms counter and
// delay unit, and scores each session against a queue of expected round times.
module tb_reaction_round_ctrl;

    localparam int NR    = 4;
    localparam int CW    = 16;
    localparam int MAXMS = 9999;
`ifdef FALSE_START_EN
    localparam bit FS_ON = 1'b1;
`else
    localparam bit FS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_ms = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          delay_done = 1'b0;
    logic          delay_trigger, lfsr_en, count_clr, count_en;
    logic          round_valid, false_start, busy, done;
    logic [CW-1:0] count;
    logic [CW-1:0] round_time, best_time, avg_time;
    logic [3:0]    round_idx;

    int n_vec = 0;
    int n_err = 0;
    int q_times[$];

    reaction_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW), .MAX_MS(MAXMS)) dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .start(start), .stop(stop),
        .delay_trigger(delay_trigger), .delay_done(delay_done), .lfsr_en(lfsr_en),
        .count_clr(count_clr), .count_en(count_en), .count(count),
        .round_time(round_time), .best_time(best_time), .avg_time(avg_time),
        .round_valid(round_valid), .false_start(false_start), .busy(busy),
        .done(done), .round_idx(round_idx)
    );

    always #5 clk = ~clk;

    // External ms reaction counter.
    always @(posedge clk) begin
        if (rst || count_clr)         count <= '0;
        else if (count_en && tick_ms) count <= count + CW'(1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, need the run to finish");
        $fatal(1, "watchdog");
    end

    function automatic int model_best();
        int b = (1 << CW) - 1;
        foreach (q_times[i]) if (q_times[i] < b) b = q_times[i];
        return b;
    endfunction

    function automatic int model_avg();
        int s = 0;
        foreach (q_times[i]) s += q_times[i];
        return s / NR;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        start = 1'b1;
        step();
        start = 1'b0;
        q_times.delete();
    endtask

    task automatic wait_arm();
        int n = 0;
        while (delay_trigger !== 1'b1 && n < 20) begin step(); n++; end
        n_vec++;
        if (delay_trigger !== 1'b1 || count_clr !== 1'b1) begin
            n_err++;
            $display("FAIL arm: delay_trigger=%b count_clr=%b after %0d cycles, need 1/1", delay_trigger, count_clr, n);
        end
        step();
        n_vec++;
        if (delay_trigger !== 1'b0 || count_clr !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL arm_width: delay_trigger=%b count_clr=%b busy=%b, need 0/0/1", delay_trigger, count_clr, busy);
        end
    endtask

    task automatic pulse_delay();
        repeat ($urandom_range(0, 4)) step();
        delay_done = 1'b1;
        step();
        delay_done = 1'b0;
    endtask

    task automatic measure_and_press(input int target, input bit hold);
        int n = 0;
        n_vec++;
        if (count_en !== 1'b1) begin
            n_err++;
            $display("FAIL measure_entry: count_en=%b, need 1", count_en);
        end
        tick_ms = 1'b1;
        while (int'(count) < target && n < 20000) begin step(); n++; end
        tick_ms = 1'b0;
        stop = 1'b1;
        n = 0;
        do begin step(); n++; end while (round_valid !== 1'b1 && n < 10);
        n_vec++;
        if (round_valid !== 1'b1 || n != 3) begin
            n_err++;
            $display("FAIL stop_latency: round_valid=%b after %0d edges, need 1 after 3", round_valid, n);
        end
        q_times.push_back(target);
        n_vec++;
        if (round_time !== CW'(target) || round_idx !== 4'(q_times.size())) begin
            n_err++;
            $display("FAIL round_time: got %0d idx %0d, need %0d idx %0d", round_time, round_idx, target, q_times.size());
        end
        if (!hold) stop = 1'b0;
        tick_ms = 1'b1;
    endtask

    task automatic do_round(input int target);
        wait_arm();
        pulse_delay();
        measure_and_press(target, 1'b0);
    endtask

    task automatic test_reset();
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) step();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || lfsr_en !== 1'b0 || delay_trigger !== 1'b0 ||
            count_clr !== 1'b0 || count_en !== 1'b0 || round_valid !== 1'b0 || false_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: busy=%b done=%b lfsr=%b trig=%b clr=%b en=%b rv=%b fs=%b, need all 0",
                     busy, done, lfsr_en, delay_trigger, count_clr, count_en, round_valid, false_start);
        end
        n_vec++;
        if (round_time !== '0 || avg_time !== '0 || best_time !== '1 || round_idx !== 4'd0) begin
            n_err++;
            $display("FAIL reset_data: rt=%0d avg=%0d best=%h idx=%0d, need 0/0/ffff/0", round_time, avg_time, best_time, round_idx);
        end
        rst = 1'b0;
        repeat (4) step();
        n_vec++;
        if (busy !== 1'b0 || lfsr_en !== 1'b1) begin
            n_err++;
            $display("FAIL held_start: busy=%b lfsr_en=%b, need 0/1", busy, lfsr_en);
        end
        start = 1'b0;
        stop  = 1'b0;
        step();
        delay_done = 1'b1;
        step();
        delay_done = 1'b0;
        step();
        n_vec++;
        if (busy !== 1'b0 || count_en !== 1'b0) begin
            n_err++;
            $display("FAIL idle_delay_done: busy=%b count_en=%b, need 0/0", busy, count_en);
        end
    endtask

    task automatic test_directed_session();
        int tgt[4] = '{250, 180, 300, 210};
        start_session();
        foreach (tgt[i]) do_round(tgt[i]);
        step(); step();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || round_idx !== 4'd4 || round_valid !== 1'b0) begin
            n_err++;
            $display("FAIL directed_finish: done=%b busy=%b idx=%0d rv=%b, need 1/0/4/0", done, busy, round_idx, round_valid);
        end
        n_vec++;
        if (best_time !== CW'(180) || avg_time !== CW'(235)) begin
            n_err++;
            $display("FAIL directed_stats: best=%0d avg=%0d, need 180/235", best_time, avg_time);
        end
    endtask

    task automatic test_random_sessions();
        for (int s = 0; s < 3; s++) begin
            start_session();
            step();
            n_vec++;
            if (best_time !== '1 || round_idx !== 4'd0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL restart: best=%h idx=%0d busy=%b, need ffff/0/1", best_time, round_idx, busy);
            end
            for (int r = 0; r < NR; r++) do_round(int'($urandom_range(1, 600)));
            step(); step();
            n_vec++;
            if (done !== 1'b1 || round_idx !== 4'(NR) || best_time !== CW'(model_best()) || avg_time !== CW'(model_avg())) begin
                n_err++;
                $display("FAIL random_session%0d: done=%b idx=%0d best=%0d avg=%0d, need 1/%0d/%0d/%0d",
                         s, done, round_idx, best_time, avg_time, NR, model_best(), model_avg());
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        start_session();
        wait_arm();
        pulse_delay();
        tick_ms = 1'b1;
        while (round_valid !== 1'b1 && n < 10200) begin step(); n++; end
        q_times.push_back(MAXMS);
        n_vec++;
        if (round_valid !== 1'b1 || round_time !== CW'(MAXMS)) begin
            n_err++;
            $display("FAIL timeout: round_valid=%b round_time=%0d, need 1/%0d", round_valid, round_time, MAXMS);
        end
        for (int r = 1; r < NR; r++) do_round(int'($urandom_range(1, 500)));
        step(); step();
        n_vec++;
        if (done !== 1'b1 || best_time !== CW'(model_best()) || avg_time !== CW'(model_avg())) begin
            n_err++;
            $display("FAIL timeout_stats: done=%b best=%0d avg=%0d, need 1/%0d/%0d", done, best_time, avg_time, model_best(), model_avg());
        end
    endtask

    task automatic test_false_start();
        int n = 0;
        start_session();
        wait_arm();
        stop = 1'b1;
        if (FS_ON) begin
            do begin step(); n++; end while (round_valid !== 1'b1 && n < 10);
            q_times.push_back(MAXMS);
            n_vec++;
            if (round_valid !== 1'b1 || n != 3 || round_time !== CW'(MAXMS) || false_start !== 1'b1) begin
                n_err++;
                $display("FAIL false_start: rv=%b edges=%0d rt=%0d fs=%b, need 1/3/%0d/1", round_valid, n, round_time, MAXMS, false_start);
            end
            stop = 1'b0;
        end else begin
            repeat (4) step();
            n_vec++;
            if (round_valid !== 1'b0 || busy !== 1'b1 || count_en !== 1'b0 || false_start !== 1'b0) begin
                n_err++;
                $display("FAIL stop_ignored: rv=%b busy=%b count_en=%b fs=%b, need 0/1/0/0", round_valid, busy, count_en, false_start);
            end
            stop = 1'b0;
            pulse_delay();
            measure_and_press(int'($urandom_range(1, 500)), 1'b0);
        end
        for (int r = 1; r < NR; r++) do_round(int'($urandom_range(1, 500)));
        step(); step();
        n_vec++;
        if (done !== 1'b1 || false_start !== FS_ON || best_time !== CW'(model_best()) || avg_time !== CW'(model_avg())) begin
            n_err++;
            $display("FAIL false_start_session: done=%b fs=%b best=%0d avg=%0d, need 1/%b/%0d/%0d",
                     done, false_start, best_time, avg_time, FS_ON, model_best(), model_avg());
        end
        start_session();
        step();
        n_vec++;
        if (false_start !== 1'b0) begin
            n_err++;
            $display("FAIL false_start_clear: fs=%b, need 0", false_start);
        end
        for (int r = 0; r < NR; r++) do_round(int'($urandom_range(1, 500)));
        step(); step();
    endtask

    task automatic test_same_cycle();
        start_session();
        wait_arm();
        stop = 1'b1;
        step();
        delay_done = 1'b1;
        step();
        delay_done = 1'b0;
        tick_ms = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (round_valid !== 1'b0 || count_en !== 1'b1) begin
                n_err++;
                $display("FAIL same_cycle[%0d]: rv=%b count_en=%b, need 0/1", i, round_valid, count_en);
            end
            step();
        end
        n_vec++;
        if (round_idx !== 4'd0 || false_start !== 1'b0) begin
            n_err++;
            $display("FAIL same_cycle_idx: idx=%0d fs=%b, need 0/0", round_idx, false_start);
        end
        stop = 1'b0;
        step();
        measure_and_press(int'($urandom_range(100, 400)), 1'b0);
        for (int r = 1; r < NR; r++) do_round(int'($urandom_range(1, 400)));
        step(); step();
        n_vec++;
        if (done !== 1'b1 || best_time !== CW'(model_best()) || avg_time !== CW'(model_avg())) begin
            n_err++;
            $display("FAIL same_cycle_stats: done=%b best=%0d avg=%0d, need 1/%0d/%0d", done, best_time, avg_time, model_best(), model_avg());
        end
    endtask

    task automatic test_busy_start_and_held_stop();
        start_session();
        wait_arm();
        pulse_delay();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        n_vec++;
        if (busy !== 1'b1 || count_en !== 1'b1 || delay_trigger !== 1'b0 || round_idx !== 4'd0) begin
            n_err++;
            $display("FAIL busy_start: busy=%b count_en=%b trig=%b idx=%0d, need 1/1/0/0", busy, count_en, delay_trigger, round_idx);
        end
        measure_and_press(int'($urandom_range(20, 300)), 1'b1);
        wait_arm();
        pulse_delay();
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (round_valid !== 1'b0 || count_en !== 1'b1) begin
                n_err++;
                $display("FAIL held_stop[%0d]: rv=%b count_en=%b, need 0/1", i, round_valid, count_en);
            end
            step();
        end
        stop = 1'b0;
        step();
        measure_and_press(int'($urandom_range(100, 400)), 1'b0);
        for (int r = 2; r < NR; r++) do_round(int'($urandom_range(1, 400)));
        step(); step();
        n_vec++;
        if (done !== 1'b1 || round_idx !== 4'(NR) || best_time !== CW'(model_best()) || avg_time !== CW'(model_avg())) begin
            n_err++;
            $display("FAIL held_stop_stats: done=%b idx=%0d best=%0d avg=%0d, need 1/%0d/%0d/%0d",
                     done, round_idx, best_time, avg_time, NR, model_best(), model_avg());
        end
    endtask

    task automatic test_reset_mid();
        start_session();
        do_round(int'($urandom_range(1, 500)));
        wait_arm();
        pulse_delay();
        tick_ms = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        step();
        n_vec++;
        if (busy !== 1'b0 || round_idx !== 4'd0 || best_time !== '1 || done !== 1'b0 ||
            count_en !== 1'b0 || round_valid !== 1'b0 || lfsr_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b idx=%0d best=%h done=%b en=%b rv=%b lfsr=%b, need 0/0/ffff/0/0/0/0",
                     busy, round_idx, best_time, done, count_en, round_valid, lfsr_en);
        end
        rst = 1'b0;
        q_times.delete();
        step();
        n_vec++;
        if (busy !== 1'b0 || lfsr_en !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_idle: busy=%b lfsr_en=%b, need 0/1", busy, lfsr_en);
        end
    endtask

    initial begin
        test_reset();
        test_directed_session();
        test_random_sessions();
        test_timeout();
        test_false_start();
        test_same_cycle();
        test_busy_start_and_held_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
